// File: rtl/sys_rst_sequencer.sv
// Board-level reset conditioner: debounced pads, lock supervision and a software
// request feed a hold/staged-release FSM with a sticky cause record and a wake pulse.
module sys_rst_sequencer #(
   parameter int NUM_SRC     = 2,
   parameter int NUM_STAGES  = 3,
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 64,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC-1:0]    rst_src_n,
   input  logic                  locked,
   input  logic                  sw_rst_req,
   input  logic                  wake_n,
   input  logic                  cause_clr,
   output logic [NUM_STAGES-1:0] rst_out_n,
   output logic                  all_released,
   output logic                  wake_pulse,
   output logic [NUM_SRC+1:0]    rst_cause,
   output logic [1:0]            dbg_state
);

   localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_STAGES - 1);

   // dbg_state encoding: 0 RESET, 1 HOLD, 2 RELEASE, 3 RUN
   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   logic [NUM_SRC-1:0]    src_s1_q, src_s2_q;
   logic                  lock_s1_q, lock_s2_q;
   logic                  wake_s1_q, wake_s2_q;
   logic [NUM_SRC-1:0]    src_deb_q;
   logic [CNT_W-1:0]      src_cnt_q [NUM_SRC];
   logic                  wake_deb_q;
   logic [CNT_W-1:0]      wake_cnt_q;
   logic                  wake_pulse_q;
   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [STG_W-1:0]      stage_q;
   logic [NUM_STAGES-1:0] rst_out_q;
   logic                  all_rel_q;
   logic [NUM_SRC+1:0]    cause_q;

   logic [NUM_SRC+1:0]    cond_bits;
   logic                  cond;
   logic [NUM_SRC+1:0]    cause_base;
   logic                  wake_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_s1_q  <= '0;
         src_s2_q  <= '0;
         lock_s1_q <= 1'b0;
         lock_s2_q <= 1'b0;
         wake_s1_q <= 1'b0;
         wake_s2_q <= 1'b0;
      end else begin
         src_s1_q  <= rst_src_n;
         src_s2_q  <= src_s1_q;
         lock_s1_q <= locked;
         lock_s2_q <= lock_s1_q;
         wake_s1_q <= wake_n;
         wake_s2_q <= wake_s1_q;
      end
   end

   // A level change is accepted only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_deb_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            src_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_s2_q[i] == src_deb_q[i]) begin
               src_cnt_q[i] <= '0;
            end else if (src_cnt_q[i] == DEB_LAST) begin
               src_deb_q[i] <= src_s2_q[i];
               src_cnt_q[i] <= '0;
            end else begin
               src_cnt_q[i] <= src_cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign wake_fall = (wake_s2_q != wake_deb_q) && (wake_cnt_q == DEB_LAST) && wake_deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wake_deb_q   <= 1'b1;
         wake_cnt_q   <= '0;
         wake_pulse_q <= 1'b0;
      end else begin
         wake_pulse_q <= wake_fall;
         if (wake_s2_q == wake_deb_q) begin
            wake_cnt_q <= '0;
         end else if (wake_cnt_q == DEB_LAST) begin
            wake_deb_q <= wake_s2_q;
            wake_cnt_q <= '0;
         end else begin
            wake_cnt_q <= wake_cnt_q + CNT_W'(1);
         end
      end
   end

   assign cond_bits  = {sw_rst_req, ~lock_s2_q, ~src_deb_q};
   assign cond       = |cond_bits;
   // A clear and a new cause on the same edge: the new cause survives.
   assign cause_base = cause_clr ? '0 : cause_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         stage_q   <= '0;
         rst_out_q <= '0;
         all_rel_q <= 1'b0;
         cause_q   <= '0;
      end else begin
         cause_q <= cause_base;
         case (state_q)
            ST_RESET: begin
               rst_out_q <= '0;
               all_rel_q <= 1'b0;
               if (!cond) begin
                  state_q <= ST_HOLD;
                  cnt_q   <= '0;
                  stage_q <= '0;
               end
            end
            ST_HOLD: begin
               if (cond) begin
                  state_q   <= ST_RESET;
                  rst_out_q <= '0;
                  all_rel_q <= 1'b0;
                  cause_q   <= cause_base | cond_bits;
               end else if (cnt_q == HOLD_LAST) begin
                  cnt_q        <= '0;
                  rst_out_q[0] <= 1'b1;
                  stage_q      <= STG_W'(1);
                  if (NUM_STAGES == 1) begin
                     state_q   <= ST_RUN;
                     all_rel_q <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (cond) begin
                  state_q   <= ST_RESET;
                  rst_out_q <= '0;
                  all_rel_q <= 1'b0;
                  cause_q   <= cause_base | cond_bits;
               end else if (cnt_q == GAP_LAST) begin
                  cnt_q              <= '0;
                  rst_out_q[stage_q] <= 1'b1;
                  if (stage_q == LAST_STG) begin
                     state_q   <= ST_RUN;
                     all_rel_q <= 1'b1;
                  end else begin
                     stage_q <= stage_q + STG_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (cond) begin
                  state_q   <= ST_RESET;
                  rst_out_q <= '0;
                  all_rel_q <= 1'b0;
                  cause_q   <= cause_base | cond_bits;
               end
            end
            default: begin
               state_q   <= ST_RESET;
               rst_out_q <= '0;
               all_rel_q <= 1'b0;
            end
         endcase
      end
   end

   assign rst_out_n    = rst_out_q;
   assign all_released = all_rel_q;
   assign wake_pulse   = wake_pulse_q;
   assign rst_cause    = cause_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// Bench for sys_rst_sequencer: directed scenarios plus random pad/lock/wake traffic,
// every cycle compared against a timing model built from the release/debounce rules.
module tb_sys_rst_sequencer;

   localparam int NS   = 2;
   localparam int NST  = 3;
   localparam int DEB  = 4;
   localparam int HOLD = 8;
   localparam int GAP  = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NS-1:0]  rst_src_n;
   logic           locked;
   logic           sw_rst_req;
   logic           wake_n;
   logic           cause_clr;
   logic [NST-1:0] rst_out_n;
   logic           all_released;
   logic           wake_pulse;
   logic [NS+1:0]  rst_cause;
   logic [1:0]     dbg_state;

   sys_rst_sequencer #(
      .NUM_SRC(NS), .NUM_STAGES(NST), .DEB_CYCLES(DEB),
      .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rst_src_n(rst_src_n), .locked(locked),
      .sw_rst_req(sw_rst_req), .wake_n(wake_n), .cause_clr(cause_clr),
      .rst_out_n(rst_out_n), .all_released(all_released), .wake_pulse(wake_pulse),
      .rst_cause(rst_cause), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   // Reference model: synced samples are the raw values two edges old; a pad's
   // debounced level follows once the synced value has held for DEB samples;
   // outputs follow from the number of edges since the reset conditions cleared.
   logic [NS-1:0] m_src_h[$];
   logic          m_lock_h[$];
   logic          m_wake_h[$];
   logic [NS-1:0] m_src_deb, m_src_last;
   int            m_src_run [NS];
   logic          m_wake_deb, m_wake_last;
   int            m_wake_run;
   bit            m_active;
   int            m_t;
   logic [NS+1:0] m_cause;
   logic          m_pulse;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_src_h  = '{'0, '0};
      m_lock_h = '{1'b0, 1'b0};
      m_wake_h = '{1'b0, 1'b0};
      m_src_deb  = '0;
      m_src_last = '0;
      for (int i = 0; i < NS; i++) m_src_run[i] = 0;
      m_wake_deb  = 1'b1;
      m_wake_last = 1'b0;
      m_wake_run  = 0;
      m_active = 1'b0;
      m_t      = 0;
      m_cause  = '0;
      m_pulse  = 1'b0;
      edge_n   = 0;
   endfunction

   function automatic void model_edge();
      logic [NS-1:0] s_src;
      logic          s_lock, s_wake;
      logic [NS+1:0] bits, base;
      s_src  = m_src_h[0];  void'(m_src_h.pop_front());  m_src_h.push_back(rst_src_n);
      s_lock = m_lock_h[0]; void'(m_lock_h.pop_front()); m_lock_h.push_back(locked);
      s_wake = m_wake_h[0]; void'(m_wake_h.pop_front()); m_wake_h.push_back(wake_n);
      bits = {sw_rst_req, ~s_lock, ~m_src_deb};
      base = cause_clr ? '0 : m_cause;
      if (!m_active) begin
         if (bits == '0) begin
            m_active = 1'b1;
            m_t      = 0;
         end
         m_cause = base;
      end else if (bits != '0) begin
         m_active = 1'b0;
         m_cause  = base | bits;
      end else begin
         m_cause = base;
         if (m_t < 1000000) m_t++;
      end
      for (int i = 0; i < NS; i++) begin
         if (s_src[i] == m_src_last[i]) m_src_run[i]++;
         else begin
            m_src_last[i] = s_src[i];
            m_src_run[i]  = 1;
         end
         if (s_src[i] != m_src_deb[i] && m_src_run[i] >= DEB) m_src_deb[i] = s_src[i];
      end
      if (s_wake == m_wake_last) m_wake_run++;
      else begin
         m_wake_last = s_wake;
         m_wake_run  = 1;
      end
      m_pulse = 1'b0;
      if (s_wake != m_wake_deb && m_wake_run >= DEB) begin
         m_pulse    = m_wake_deb;
         m_wake_deb = s_wake;
      end
   endfunction

   task automatic step();
      logic [NST-1:0] e_out;
      logic           e_all;
      logic [1:0]     e_st;
      model_edge();
      @(posedge clk);
      #1;
      edge_n++;
      for (int k = 0; k < NST; k++) e_out[k] = m_active && (m_t >= HOLD + k * GAP);
      e_all = m_active && (m_t >= HOLD + (NST - 1) * GAP);
      e_st  = !m_active ? 2'd0 : (m_t < HOLD) ? 2'd1 : e_all ? 2'd3 : 2'd2;
      chk("rst_out_n", 32'(rst_out_n), 32'(e_out));
      chk("all_released", 32'(all_released), 32'(e_all));
      chk("wake_pulse", 32'(wake_pulse), 32'(m_pulse));
      chk("rst_cause", 32'(rst_cause), 32'(m_cause));
      chk("state", 32'(dbg_state), 32'(e_st));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, r1, r2, ra, drop, k, found, pulses, pstep;
      int src_cnt [NS];
      int lock_cnt, wake_cnt, sel;
      rst_n = 1'b0; rst_src_n = '1; locked = 1'b1; sw_rst_req = 1'b0;
      wake_n = 1'b1; cause_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rst_out_n", 32'(rst_out_n), 32'd0);
      chk("reset_all_released", 32'(all_released), 32'd0);
      chk("reset_wake_pulse", 32'(wake_pulse), 32'd0);
      chk("reset_rst_cause", 32'(rst_cause), 32'd0);

      // Power-up release schedule.
      rst_n = 1'b1;
      model_reset();
      r0 = 0; r1 = 0; r2 = 0; ra = 0;
      repeat (25) begin
         step();
         if (rst_out_n[0] && r0 == 0) r0 = edge_n;
         if (rst_out_n[1] && r1 == 0) r1 = edge_n;
         if (rst_out_n[2] && r2 == 0) r2 = edge_n;
         if (all_released && ra == 0) ra = edge_n;
      end
      chk("stage0_edge", 32'(r0), 32'd15);
      chk("stage1_edge", 32'(r1), 32'd17);
      chk("stage2_edge", 32'(r2), 32'd19);
      chk("all_rel_edge", 32'(ra), 32'd19);
      chk("startup_cause", 32'(rst_cause), 32'd0);

      // Short pad glitch in RUN is absorbed.
      rst_src_n[1] = 1'b0;
      repeat (3) step();
      rst_src_n[1] = 1'b1;
      repeat (10) step();
      chk("glitch_rst_out", 32'(rst_out_n), 32'd7);
      chk("glitch_all_rel", 32'(all_released), 32'd1);

      // Pad held low 6 cycles resets, then re-sequences.
      drop = 0;
      for (k = 1; k <= 12; k++) begin
         rst_src_n[1] = (k <= 6) ? 1'b0 : 1'b1;
         step();
         if (rst_out_n == '0 && drop == 0) drop = k;
      end
      chk("pad_drop_step", 32'(drop), 32'd7);
      chk("pad_cause", 32'(rst_cause), 32'b0010);
      found = 0;
      for (k = 1; k <= 40 && found == 0; k++) begin
         step();
         if (rst_out_n[0]) found = k;
      end
      chk("pad_rerelease_wait", 32'(found), 32'd9);

      // Lock drop during RELEASE, cause cleared on the same step.
      locked = 1'b0; cause_clr = 1'b1;
      step();
      locked = 1'b1; cause_clr = 1'b0;
      drop = 0; found = 0;
      for (k = 2; k <= 20; k++) begin
         step();
         if (rst_out_n == '0 && drop == 0) drop = k;
         if (drop != 0 && rst_out_n[0] && found == 0) found = k;
      end
      chk("lock_drop_step", 32'(drop), 32'd3);
      chk("lock_rerelease_step", 32'(found), 32'd12);
      chk("lock_cause", 32'(rst_cause), 32'b0100);

      // Software reset together with a cause clear.
      found = 0;
      for (k = 1; k <= 40 && found == 0; k++) begin
         step();
         if (all_released) found = 1;
      end
      chk("sw_wait_run", 32'(found), 32'd1);
      sw_rst_req = 1'b1; cause_clr = 1'b1;
      step();
      sw_rst_req = 1'b0; cause_clr = 1'b0;
      chk("sw_rst_out", 32'(rst_out_n), 32'd0);
      chk("sw_cause", 32'(rst_cause), 32'b1000);
      chk("sw_state_reset", 32'(dbg_state), 32'd0);
      step();
      chk("sw_state_hold", 32'(dbg_state), 32'd1);

      // Wake: long low gives one pulse 6 steps in; a 2-cycle glitch gives none.
      pulses = 0; pstep = 0;
      for (k = 1; k <= 25; k++) begin
         wake_n = (k <= 10) ? 1'b0 : 1'b1;
         step();
         if (wake_pulse) begin
            pulses++;
            pstep = k;
         end
      end
      chk("wake_pulses", 32'(pulses), 32'd1);
      chk("wake_pulse_step", 32'(pstep), 32'd6);
      pulses = 0;
      for (k = 1; k <= 15; k++) begin
         wake_n = (k <= 2) ? 1'b0 : 1'b1;
         step();
         if (wake_pulse) pulses++;
      end
      chk("wake_glitch_pulses", 32'(pulses), 32'd0);

      // Random traffic on every input.
      for (int i = 0; i < NS; i++) src_cnt[i] = 0;
      lock_cnt = 0; wake_cnt = 0;
      repeat (1500) begin
         sel = $urandom_range(0, 99);
         sw_rst_req = 1'b0; cause_clr = 1'b0;
         if (sel < 2) src_cnt[$urandom_range(0, NS - 1)] = $urandom_range(1, 8);
         else if (sel == 2) lock_cnt = $urandom_range(1, 3);
         else if (sel == 3) sw_rst_req = 1'b1;
         else if (sel == 4) cause_clr = 1'b1;
         else if (sel < 8) wake_cnt = $urandom_range(1, 8);
         for (int i = 0; i < NS; i++) begin
            rst_src_n[i] = (src_cnt[i] > 0) ? 1'b0 : 1'b1;
            if (src_cnt[i] > 0) src_cnt[i]--;
         end
         locked = (lock_cnt > 0) ? 1'b0 : 1'b1;
         if (lock_cnt > 0) lock_cnt--;
         wake_n = (wake_cnt > 0) ? 1'b0 : 1'b1;
         if (wake_cnt > 0) wake_cnt--;
         step();
      end
      rst_src_n = '1; locked = 1'b1; wake_n = 1'b1; sw_rst_req = 1'b0; cause_clr = 1'b0;

      // Asynchronous reset in the middle of RELEASE.
      found = 0;
      for (k = 1; k <= 80 && found == 0; k++) begin
         step();
         if (all_released) found = 1;
      end
      chk("arst_wait_run", 32'(found), 32'd1);
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      found = 0;
      for (k = 1; k <= 30 && found == 0; k++) begin
         step();
         if (rst_out_n == 3'b001) found = 1;
      end
      chk("arst_wait_release", 32'(found), 32'd1);
      chk("arst_cause_before", 32'(rst_cause[NS+1]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_rst_out", 32'(rst_out_n), 32'd0);
      chk("arst_all_rel", 32'(all_released), 32'd0);
      chk("arst_cause", 32'(rst_cause), 32'd0);
      chk("arst_state", 32'(dbg_state), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("arst_held_rst_out", 32'(rst_out_n), 32'd0);
      rst_n = 1'b1;
      model_reset();
      repeat (25) step();
      chk("arst_recovered", 32'(all_released), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
